bus_arb_outstanding: RTL

// Parametrised host/device bus for demo and simulation systems. Adds selectable fixed-priority or

---
 rtl/bus_arb_outstanding.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bus_arb_outstanding.sv
// bus_arb_outstanding: host/device bus with fixed or round-robin arbitration, grant lock
// and an in-order response FIFO that allows up to MaxOutstanding transfers in flight.
module bus_arb_outstanding #(
    parameter int NrDevices      = 1,
    parameter int NrHosts        = 1,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 2,
    parameter bit ArbRoundRobin  = 1'b0
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NrHosts-1:0]                       host_req_i,
    output logic [NrHosts-1:0]                       host_gnt_o,
    input  logic [NrHosts-1:0][AddressWidth-1:0]     host_addr_i,
    input  logic [NrHosts-1:0]                       host_we_i,
    input  logic [NrHosts-1:0][DataWidth/8-1:0]      host_be_i,
    input  logic [NrHosts-1:0][DataWidth-1:0]        host_wdata_i,
    output logic [NrHosts-1:0]                       host_rvalid_o,
    output logic [NrHosts-1:0][DataWidth-1:0]        host_rdata_o,
    output logic [NrHosts-1:0]                       host_err_o,
    output logic [NrDevices-1:0]                     device_req_o,
    input  logic [NrDevices-1:0]                     device_gnt_i,
    output logic [NrDevices-1:0][AddressWidth-1:0]   device_addr_o,
    output logic [NrDevices-1:0]                     device_we_o,
    output logic [NrDevices-1:0][DataWidth/8-1:0]    device_be_o,
    output logic [NrDevices-1:0][DataWidth-1:0]      device_wdata_o,
    input  logic [NrDevices-1:0]                     device_rvalid_i,
    input  logic [NrDevices-1:0][DataWidth-1:0]      device_rdata_i,
    input  logic [NrDevices-1:0]                     device_err_i,
    input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_base,
    input  logic [NrDevices-1:0][AddressWidth-1:0]   cfg_device_addr_mask
);
    localparam int HW  = NrHosts > 1 ? $clog2(NrHosts) : 1;
    localparam int DVW = NrDevices > 1 ? $clog2(NrDevices) : 1;
    localparam int PW  = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
    localparam int CW  = $clog2(MaxOutstanding + 1);

    logic [HW-1:0]                     arb_idx, win, lock_host, rr_ptr, head;
    logic                              arb_valid, win_valid, lock_q;
    logic [DVW-1:0]                    win_dev, tgt_dev;
    logic                              win_err, tgt_err;
    logic                              stall, issue, accept, pop;
    logic [CW-1:0]                     count;
    logic [PW-1:0]                     wr_ptr, rd_ptr;
    logic [MaxOutstanding-1:0][HW-1:0] fifo;

    // Iterating downwards lets the last hit be the highest-priority candidate.
    always_comb begin
        arb_idx   = '0;
        arb_valid = 1'b0;
        for (int k = NrHosts; k >= 1; k--)
            if (host_req_i[ArbRoundRobin ? (int'(rr_ptr) + k) % NrHosts : k - 1]) begin
                arb_valid = 1'b1;
                arb_idx   = HW'(ArbRoundRobin ? (int'(rr_ptr) + k) % NrHosts : k - 1);
            end
    end

    assign win       = lock_q ? lock_host : arb_idx;
    assign win_valid = rst_ni & (lock_q | arb_valid);

    always_comb begin
        win_dev = '0;
        win_err = 1'b1;
        for (int d = NrDevices - 1; d >= 0; d--)
            if ((host_addr_i[win] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                win_dev = DVW'(d);
                win_err = 1'b0;
            end
    end

    // All queued entries share one target, so a target switch waits for the FIFO to drain.
    assign stall  = (count == CW'(MaxOutstanding)) |
                    ((count != '0) & ({win_err, win_dev} != {tgt_err, tgt_dev}));
    assign issue  = win_valid & ~win_err & ~stall;
    assign accept = win_valid & (win_err ? ~stall : issue & device_gnt_i[win_dev]);
    assign head   = fifo[rd_ptr];
    assign pop    = (count != '0) & (tgt_err | device_rvalid_i[tgt_dev]);

    always_comb begin
        device_req_o   = '0;
        device_addr_o  = '0;
        device_we_o    = '0;
        device_be_o    = '0;
        device_wdata_o = '0;
        host_gnt_o     = '0;
        host_rvalid_o  = '0;
        host_rdata_o   = '0;
        host_err_o     = '0;
        if (issue) begin
            device_req_o[win_dev]   = 1'b1;
            device_addr_o[win_dev]  = host_addr_i[win];
            device_we_o[win_dev]    = host_we_i[win];
            device_be_o[win_dev]    = host_be_i[win];
            device_wdata_o[win_dev] = host_wdata_i[win];
        end
        host_gnt_o[win] = accept;
        if (pop) begin
            host_rvalid_o[head] = 1'b1;
            host_rdata_o[head]  = tgt_err ? '0 : device_rdata_i[tgt_dev];
            host_err_o[head]    = tgt_err | device_err_i[tgt_dev];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo      <= '0;
            tgt_err   <= 1'b0;
            tgt_dev   <= '0;
            lock_q    <= 1'b0;
            lock_host <= '0;
            rr_ptr    <= HW'(NrHosts - 1);
        end else begin
            lock_q    <= issue & ~device_gnt_i[win_dev];
            lock_host <= win;
            if (accept) begin
                fifo[wr_ptr] <= win;
                wr_ptr       <= (wr_ptr == PW'(MaxOutstanding - 1)) ? '0 : wr_ptr + 1'b1;
                tgt_err      <= win_err;
                tgt_dev      <= win_dev;
                rr_ptr       <= win;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PW'(MaxOutstanding - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(accept) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i)
        if (rst_ni)
            for (int d = 0; d < NrDevices; d++)
                assert (!device_rvalid_i[d] || (count != '0 && !tgt_err && DVW'(d) == tgt_dev))
                else $error("unexpected response from device %0d", d);
endmodule
